pipelined_add_sub: RTL

//  Parametrised, pipelined adder/subtractor with valid/ready handshake. Replaces the flat 32-bit ripple adder on timing-critical paths.

---
 rtl/addsub_pkg.sv | 16 +
 rtl/pipelined_add_sub_if.sv | 34 +++
 rtl/pipelined_add_sub_add_chunk.sv | 23 ++
 rtl/pipelined_add_sub.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
//   addsub_mode_e : operation select (ADD = A+B+cin, SUB = A-B)
//   ovf_calc      : signed overflow from the operand/result MSBs
package addsub_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } addsub_mode_e;

  // Overflow when both effective operands share a sign the result does not.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Handshake/data bundle of the pipelined adder/subtractor.
//   valid_i/ready_o      : operand handshake (ready_o is combinational)
//   A_i, Y_i, C_i, sub_i : operands, carry-in, mode
//   valid_o/ready_i      : result handshake
//   Sum_o, c_o, ovf_o, zero_o : result and flags
// slave modport is the adder side, master modport is the operand/result user.
interface pipelined_add_sub_if #(
  parameter int unsigned WIDTH = 32
);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] Y_i;
  logic             C_i;
  logic             sub_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] Sum_o;
  logic             c_o;
  logic             ovf_o;
  logic             zero_o;

  modport slave (
    input  valid_i, A_i, Y_i, C_i, sub_i, ready_i,
    output ready_o, valid_o, Sum_o, c_o, ovf_o, zero_o
  );

  modport master (
    output valid_i, A_i, Y_i, C_i, sub_i, ready_i,
    input  ready_o, valid_o, Sum_o, c_o, ovf_o, zero_o
  );

endinterface

// File: rtl/pipelined_add_sub_add_chunk.sv
// Combinational CW-bit ripple adder used for one carry-chain chunk.
//   a, b, cin : chunk operands and carry-in
//   sum, cout : chunk sum and carry-out
//   is_zero   : chunk sum is all zeros
module add_chunk #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          is_zero
);

  logic [CW:0] full;

  assign full    = {1'b0, a} + {1'b0, b} + (CW+1)'(cin);
  assign sum     = full[CW-1:0];
  assign cout    = full[CW];
  assign is_zero = ~|full[CW-1:0];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, carry chain split into STAGES chunks.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : operand handshake in, result handshake out
// Chunk k is added in stage k; unprocessed upper operand bits and the
// already-computed lower sum bits travel alongside in skew registers.
// The whole pipe advances together whenever the output slot is free or
// being drained, so ready_o is a pure function of valid_o and ready_i.
module pipelined_add_sub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipelined_add_sub_if.slave bus
);

  localparam int unsigned CW = WIDTH / STAGES;
  localparam int unsigned L  = STAGES - 1;

  if ((STAGES == 0) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_add_sub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             adv;
  logic             valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  addsub_mode_e     mode;
  logic [WIDTH-1:0] b_mod;
  logic             cin_mod;

  // Operand conditioning: subtract is A + ~B + 1, carry-in ignored.
  assign mode    = addsub_mode_e'(bus.sub_i);
  assign b_mod   = (mode == SUB) ? ~bus.Y_i : bus.Y_i;
  assign cin_mod = (mode == SUB) ? 1'b1 : bus.C_i;

  // Global advance: a free or draining output slot lets every stage shift.
  assign adv         = ~valid_q | bus.ready_i;
  assign bus.ready_o = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // IW: operand bits not yet consumed entering this stage (chunk k and above).
    // LW: result bits known after this stage's chunk is added.
    localparam int unsigned IW = WIDTH - k * CW;
    localparam int unsigned LW = (k + 1) * CW;

    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic          cin;
    logic          z_in;
    logic          v_in;
    logic [CW-1:0] sum_c;
    logic          cout_c;
    logic          zero_c;
    logic          z_out;
    logic [LW-1:0] s_out;

    add_chunk #(.CW(CW)) u_chunk (
      .a       (a_in[CW-1:0]),
      .b       (b_in[CW-1:0]),
      .cin     (cin),
      .sum     (sum_c),
      .cout    (cout_c),
      .is_zero (zero_c)
    );

    assign z_out = z_in & zero_c;

    if (k == 0) begin : g_src
      // First chunk works straight off the conditioned inputs.
      assign a_in  = bus.A_i;
      assign b_in  = b_mod;
      assign cin   = cin_mod;
      assign z_in  = 1'b1;
      assign v_in  = bus.valid_i;
      assign s_out = sum_c;
    end else begin : g_src
      localparam int unsigned SW = k * CW;

      logic [IW-1:0] a_q;
      logic [IW-1:0] b_q;
      logic [SW-1:0] s_q;
      logic          c_q;
      logic          z_q;
      logic          v_q;

      // Stage register between chunk k-1 and chunk k; bubbles shift like data.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          z_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv) begin
          a_q <= g_stage[k-1].a_in[IW+CW-1:CW];
          b_q <= g_stage[k-1].b_in[IW+CW-1:CW];
          s_q <= g_stage[k-1].s_out;
          c_q <= g_stage[k-1].cout_c;
          z_q <= g_stage[k-1].z_out;
          v_q <= g_stage[k-1].v_in;
        end
      end

      assign a_in  = a_q;
      assign b_in  = b_q;
      assign cin   = c_q;
      assign z_in  = z_q;
      assign v_in  = v_q;
      assign s_out = {sum_c, s_q};
    end
  end

  // Output register: result fields only load with a valid entry, so the
  // visible result never changes except on a handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= g_stage[L].v_in;
      if (g_stage[L].v_in) begin
        sum_q   <= g_stage[L].s_out;
        carry_q <= g_stage[L].cout_c;
        zero_q  <= g_stage[L].z_out;
        ovf_q   <= ovf_calc(g_stage[L].a_in[CW-1], g_stage[L].b_in[CW-1],
                            g_stage[L].sum_c[CW-1]);
      end
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.Sum_o   = sum_q;
  assign bus.c_o     = carry_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.zero_o  = zero_q;

endmodule
